qmult: RTL and testbench

- Signed two's-complement fixed-point (Q-format) multiplier, fully pipelined, one result per clock.
- Basic MAC primitive of the dense/GRU layers: multiplies activations by weights and applies the output weight scale.
- Rounds the full-precision product back to the operand format and saturates on overflow.

---
 rtl/qmult.sv | 96 +++++++++
 tb/tb_qmult.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/qmult.sv
// qmult: signed two's-complement fixed-point multiplier for Q(WIDTH-FRAC).FRAC.
// It is fully pipelined and accepts one operand pair per clock, with a latency of 2 edges.
//   Stage 1 registers both operands.
//   Stage 2 forms the exact product, rounds it half-up back to FRAC fractional bits,
//   saturates it to WIDTH bits, and registers the result.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset; clears every pipeline register
//   a, b      in   WIDTH-bit signed Q-format operands
//   q_result  out  WIDTH-bit rounded, saturated product (registered)
//   overflow  out  high when q_result was saturated; aligned with q_result
module qmult #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q_result,
    output logic             overflow
);

    // One bit wider than the product, so adding the rounding constant cannot wrap.
    localparam int PW = 2 * WIDTH;
    localparam int XW = PW + 1;

    localparam logic [XW-1:0] ONE_X  = {{(XW-1){1'b0}}, 1'b1};
    localparam logic [XW-1:0] HALF_X = ONE_X << (FRAC - 1);
    // These are the representable result limits, sign-extended to the wide domain.
    localparam logic [XW-1:0] MAX_X  = {{(XW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic [XW-1:0] MIN_X  = {{(XW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_W = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_W = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] res_q, res_d;
    logic             ovf_q, ovf_d;

    logic [PW-1:0] prod;
    logic [XW-1:0] sum;
    logic [XW-1:0] rnd;

    // Stage 1: operand registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a;
            b_q <= b;
        end
    end

    // Both operands are sign-extended to 2*WIDTH bits.
    // The low 2*WIDTH bits of the unsigned product are then the exact signed product,
    // and this holds even for the most-negative operand.
    always_comb begin
        prod  = '0;
        sum   = '0;
        rnd   = '0;
        res_d = '0;
        ovf_d = 1'b0;

        prod = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
        sum  = {prod[PW-1], prod} + HALF_X;
        rnd  = $unsigned($signed(sum) >>> FRAC);

        if ($signed(rnd) > $signed(MAX_X)) begin
            res_d = MAX_W;
            ovf_d = 1'b1;
        end else if ($signed(rnd) < $signed(MIN_X)) begin
            res_d = MIN_W;
            ovf_d = 1'b1;
        end else begin
            res_d = rnd[WIDTH-1:0];
            ovf_d = 1'b0;
        end
    end

    // Stage 2: result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            res_q <= res_d;
            ovf_q <= ovf_d;
        end
    end

    assign q_result = res_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_qmult.sv
module tb_qmult;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Q16.16 instance
    logic [31:0] a32 = '0, b32 = '0, q32;
    logic        o32;
    // Q8.8 instance for the parameter sweep
    logic [15:0] a16 = '0, b16 = '0, q16;
    logic        o16;

    qmult #(.WIDTH(32), .FRAC(16)) dut32 (
        .clk(clk), .rst(rst), .a(a32), .b(b32), .q_result(q32), .overflow(o32)
    );
    qmult #(.WIDTH(16), .FRAC(8)) dut16 (
        .clk(clk), .rst(rst), .a(a16), .b(b16), .q_result(q16), .overflow(o16)
    );

    typedef struct packed {
        logic [31:0] r;
        logic        o;
    } exp_t;

    exp_t exp32_q[$];
    exp_t exp16_q[$];
    logic [2:0] vld32 = '0, vld16 = '0;
    logic iss32 = 1'b0, iss16 = 1'b0;
    int checks = 0;
    int errors = 0;

    // This is an independent reference model that uses 64-bit integer arithmetic.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                   input int w, input int f);
        longint sx, sy, p, r, mx, mn;
        exp_t e;
        if (w == 32) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end else begin
            sx = longint'($signed(x[15:0]));
            sy = longint'($signed(y[15:0]));
        end
        p  = sx * sy;
        r  = (p + (longint'(1) <<< (f - 1))) >>> f;
        mx = (longint'(1) <<< (w - 1)) - 1;
        mn = -(longint'(1) <<< (w - 1));
        e.o = 1'b0;
        if (r > mx) begin
            r = mx;
            e.o = 1'b1;
        end else if (r < mn) begin
            r = mn;
            e.o = 1'b1;
        end
        e.r = r[31:0];
        if (w == 16) e.r[31:16] = '0;
        return e;
    endfunction

    // This tracks which issued pairs are in flight. A sampled reset drops them,
    // just as it does in the DUT.
    always @(posedge clk) begin
        if (rst) begin
            vld32 <= '0;
            vld16 <= '0;
            exp32_q.delete();
            exp16_q.delete();
        end else begin
            vld32 <= {vld32[1:0], iss32};
            vld16 <= {vld16[1:0], iss16};
        end
    end

    // Monitor: this block pops and compares whenever a result is due on an output.
    always @(negedge clk) begin
        exp_t e;
        if (vld32[1]) begin
            checks++;
            if (exp32_q.size() == 0) begin
                errors++;
                $display("FAIL q32_underflow: result present but no expectation queued");
            end else begin
                e = exp32_q.pop_front();
                if (q32 !== e.r || o32 !== e.o) begin
                    errors++;
                    $display("FAIL q32: got %h/%b expected %h/%b", q32, o32, e.r, e.o);
                end
            end
        end
        if (vld16[1]) begin
            checks++;
            if (exp16_q.size() == 0) begin
                errors++;
                $display("FAIL q16_underflow: result present but no expectation queued");
            end else begin
                e = exp16_q.pop_front();
                if ({16'h0, q16} !== e.r || o16 !== e.o) begin
                    errors++;
                    $display("FAIL q16: got %h/%b expected %h/%b", q16, o16, e.r[15:0], e.o);
                end
            end
        end
    end

    task automatic send32(input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] r, input logic o);
        @(negedge clk);
        a32 = x; b32 = y; iss32 = 1'b1; iss16 = 1'b0;
        exp32_q.push_back('{r: r, o: o});
    endtask

    task automatic send16(input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] r, input logic o);
        @(negedge clk);
        a16 = x; b16 = y; iss16 = 1'b1; iss32 = 1'b0;
        exp16_q.push_back('{r: {16'h0, r}, o: o});
    endtask

    task automatic idle();
        @(negedge clk);
        iss32 = 1'b0; iss16 = 1'b0;
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (q32 !== 32'h0 || o32 !== 1'b0 || q16 !== 16'h0 || o16 !== 1'b0) begin
            errors++;
            $display("FAIL %s: got q32=%h o32=%b q16=%h o16=%b expected all zero",
                     name, q32, o32, q16, o16);
        end
    endtask

    initial begin
        logic [31:0] x, y;
        exp_t e;

        // The reset is held for 3 cycles with live operands. The outputs stay zero throughout.
        rst = 1'b1; a32 = 32'h0003_0000; b32 = 32'h0002_0000;
        a16 = 16'h7FFF; b16 = 16'h7FFF;
        repeat (3) begin
            @(negedge clk);
            check_zero("reset_hold");
        end
        // The first edge with rst=0 samples 3.0*2.0.
        @(negedge clk);
        rst = 1'b0; iss32 = 1'b1;
        exp32_q.push_back('{r: 32'h0006_0000, o: 1'b0});

        // Basic products
        send32(32'h0002_0000, 32'h0003_0000, 32'h0006_0000, 1'b0);
        send32(32'hFFFE_8000, 32'h0002_0000, 32'hFFFD_0000, 1'b0);
        send32(32'h0001_0000, 32'h1234_5678, 32'h1234_5678, 1'b0);
        // Rounding ties, half-up
        send32(32'h0000_0001, 32'h0000_8000, 32'h0000_0001, 1'b0);
        send32(32'hFFFF_FFFF, 32'h0000_8000, 32'h0000_0000, 1'b0);
        send32(32'h0000_0001, 32'h0000_4000, 32'h0000_0000, 1'b0);
        // Saturation, including the most-negative operand
        send32(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
        send32(32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
        send32(32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 1'b1);
        // Zero operand
        send32(32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0);

        // Mid-stream reset. The first pair completes before the reset.
        // The second pair, which would saturate, must be discarded.
        send32(32'h0002_0000, 32'h0002_0000, 32'h0004_0000, 1'b0);
        send32(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
        @(negedge clk);
        rst = 1'b1; iss32 = 1'b0;
        @(negedge clk);
        check_zero("reset_mid");
        @(negedge clk);
        check_zero("reset_mid2");
        rst = 1'b0;

        // Back-to-back streaming of random pairs
        for (int i = 0; i < 1000; i++) begin
            x = $urandom();
            y = $urandom();
            // This narrows some operands, so that unsaturated results are also exercised.
            if (i % 3 == 1) x = {{12{x[19]}}, x[19:0]};
            if (i % 3 == 2) y = {{14{y[17]}}, y[17:0]};
            e = model(x, y, 32, 16);
            send32(x, y, e.r, e.o);
        end

        // Parameter sweep, Q8.8
        send16(16'h0180, 16'h0200, 16'h0300, 1'b0);
        send16(16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1);
        send16(16'h8000, 16'h8000, 16'h7FFF, 1'b1);
        send16(16'h7FFF, 16'h8000, 16'h8000, 1'b1);
        send16(16'hFF00, 16'h0180, 16'hFE80, 1'b0);
        send16(16'h0001, 16'h0080, 16'h0001, 1'b0);
        send16(16'hFFFF, 16'h0080, 16'h0000, 1'b0);
        for (int i = 0; i < 200; i++) begin
            x = {16'h0, 16'($urandom())};
            y = {16'h0, 16'($urandom())};
            e = model(x, y, 16, 8);
            send16(x[15:0], y[15:0], e.r[15:0], e.o);
        end

        // Drain the pipeline. Every expectation must have been consumed.
        repeat (4) idle();
        checks++;
        if (exp32_q.size() != 0 || exp16_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d/%0d results never appeared, expected 0/0",
                     exp32_q.size(), exp16_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
